// File: rtl/data_mem_responder.sv
// Data-memory target for the MEM stage: one load/store at a time over valid/ready,
// response returned after WAIT_CYCLES wait states from little-endian word storage.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]      cnt;
  logic                  lat_write;
  logic [31:0]           lat_addr;
  logic [2:0]            lat_funct3;
  logic [31:0]           lat_wdata;
  logic                  access_fire;
  logic                  acc_error;
  logic [31:0]           acc_rdata;
  logic [3:0]            byte_en;
  logic [31:0]           lane_wdata;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           mem_word;
  logic [15:0]           lane_half;
  logic [31:0]           rdata_q;
  logic                  error_q;
  logic [31:0]           mem [DEPTH];

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = error_q;
  assign access_fire = (state == S_WAIT) && (cnt == '0);

  // Selected lane shifted down to bit 0; halfword alignment makes this valid for H too.
  assign word_idx  = lat_addr[ADDR_WIDTH+1:2];
  assign mem_word  = mem[word_idx];
  assign lane_half = 16'(mem_word >> {lat_addr[1:0], 3'b000});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid)     state_next = S_WAIT;
      S_WAIT:  if (cnt == '0)     state_next = S_RESP;
      S_RESP:  if (rsp_ready)     state_next = S_IDLE;
      default:                    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    acc_error  = 1'b0;
    acc_rdata  = '0;
    byte_en    = '0;
    lane_wdata = lat_wdata;
    case (lat_funct3)
      3'b000: begin
        lane_wdata = {4{lat_wdata[7:0]}};
        byte_en    = 4'b0001 << lat_addr[1:0];
        acc_rdata  = {{24{lane_half[7]}}, lane_half[7:0]};
      end
      3'b001: begin
        acc_error  = lat_addr[0];
        lane_wdata = {2{lat_wdata[15:0]}};
        byte_en    = lat_addr[1] ? 4'b1100 : 4'b0011;
        acc_rdata  = {{16{lane_half[15]}}, lane_half};
      end
      3'b010: begin
        acc_error = |lat_addr[1:0];
        byte_en   = 4'b1111;
        acc_rdata = mem_word;
      end
      3'b100: begin
        acc_error = lat_write;
        acc_rdata = {24'b0, lane_half[7:0]};
      end
      3'b101: begin
        acc_error = lat_write | lat_addr[0];
        acc_rdata = {16'b0, lane_half};
      end
      default: acc_error = 1'b1;
    endcase
    if (|lat_addr[31:ADDR_WIDTH+2]) acc_error = 1'b1;
    // Errors and stores return zero data; only error-free stores touch memory.
    if (acc_error || lat_write)  acc_rdata = '0;
    if (acc_error || !lat_write) byte_en   = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_funct3 <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_funct3 <= req_funct3;
            lat_wdata  <= req_wdata;
            cnt        <= CNT_W'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rdata_q <= acc_rdata;
            error_q <= acc_error;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            error_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; writes happen only on the WAIT->RESP edge.
  always_ff @(posedge clock) begin
    if (access_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-level reference memory predicts
// every response, plus spot checks against hand-computed constants.
module tb_data_mem_responder;

  localparam int ADDR_WIDTH  = 10;
  localparam int WAIT_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [0:(2**ADDR_WIDTH)-1];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] got_rdata;
  logic        got_err;

  data_mem_responder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_funct3(req_funct3),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: predicts the response and applies legal stores byte by byte.
  task automatic predict(input logic wr, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output exp_t e);
    int          nbytes;
    logic [31:0] word;
    logic [7:0]  b0, b1;
    e.err   = 1'b0;
    e.rdata = 32'h0;
    nbytes  = 0;
    case (f3)
      3'b000: nbytes = 1;
      3'b001: begin nbytes = 2; e.err = a[0]; end
      3'b010: begin nbytes = 4; e.err = (a[1:0] != 2'b00); end
      3'b100: begin nbytes = 1; e.err = wr; end
      3'b101: begin nbytes = 2; e.err = wr || a[0]; end
      default: e.err = 1'b1;
    endcase
    if (a[31:ADDR_WIDTH+2] != '0) e.err = 1'b1;
    if (e.err) return;
    if (wr) begin
      for (int k = 0; k < nbytes; k++)
        ref_mem[a[ADDR_WIDTH+1:2]][8*(a[1:0]+k) +: 8] = wd[8*k +: 8];
    end else begin
      word = ref_mem[a[ADDR_WIDTH+1:2]];
      b0   = word[8*a[1:0] +: 8];
      b1   = (nbytes == 2) ? word[8*(a[1:0]+1) +: 8] : 8'h00;
      case (f3)
        3'b000:  e.rdata = {{24{b0[7]}}, b0};
        3'b100:  e.rdata = {24'h0, b0};
        3'b001:  e.rdata = {{16{b1[7]}}, b1, b0};
        3'b101:  e.rdata = {16'h0, b1, b0};
        default: e.rdata = word;
      endcase
    end
  endtask

  // Issues one request, checks latency and response, optionally stalls rsp_ready.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] a,
                               input logic [2:0] f3, input logic [31:0] wd, input int hold,
                               output logic [31:0] obs_rdata, output logic obs_err);
    exp_t e;
    int   guard;
    int   lat;
    predict(wr, a, f3, wd, e);
    sb_q.push_back(e);
    obs_rdata = 32'h0;
    obs_err   = 1'b0;
    guard = 0;
    @(negedge clock);
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      checkOutput({tag, "_req_ready_timeout"}, 32'(req_ready), 32'h1);
      void'(sb_q.pop_front());
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    e = sb_q.pop_front();
    if (!rsp_valid) begin
      checkOutput({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'h1);
      return;
    end
    obs_rdata = rsp_rdata;
    obs_err   = rsp_error;
    checkOutput({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    checkOutput({tag, "_rdata"}, rsp_rdata, e.rdata);
    checkOutput({tag, "_error"}, 32'(rsp_error), 32'(e.err));
    for (int i = 1; i <= hold; i++) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'h1);
      checkOutput({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
      checkOutput({tag, "_hold_req_ready"}, 32'(req_ready), 32'h0);
      if (i == 1) begin
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h10;
        req_funct3 = 3'b010;
        req_wdata  = 32'hFFFFFFFF;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    checkOutput({tag, "_released_valid"}, 32'(rsp_valid), 32'h0);
    checkOutput({tag, "_released_idle"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_funct3 = 3'b000;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_error", 32'(rsp_error), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    applyStimulus("sw_10", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, got_rdata, got_err);
    applyStimulus("lw_10", 1'b0, 32'h10, 3'b010, 32'h0, 0, got_rdata, got_err);
    checkOutput("lw_10_const", got_rdata, 32'hDEADBEEF);

    applyStimulus("sb_13", 1'b1, 32'h13, 3'b000, 32'hABCDEF80, 0, got_rdata, got_err);
    applyStimulus("lb_13", 1'b0, 32'h13, 3'b000, 32'h0, 0, got_rdata, got_err);
    checkOutput("lb_13_const", got_rdata, 32'hFFFFFF80);
    applyStimulus("lbu_13", 1'b0, 32'h13, 3'b100, 32'h0, 0, got_rdata, got_err);
    checkOutput("lbu_13_const", got_rdata, 32'h00000080);
    applyStimulus("lw_10b", 1'b0, 32'h10, 3'b010, 32'h0, 0, got_rdata, got_err);
    checkOutput("lw_10b_const", got_rdata, 32'h80ADBEEF);

    applyStimulus("sh_16", 1'b1, 32'h16, 3'b001, 32'h1234F00D, 0, got_rdata, got_err);
    applyStimulus("lh_16", 1'b0, 32'h16, 3'b001, 32'h0, 0, got_rdata, got_err);
    checkOutput("lh_16_const", got_rdata, 32'hFFFFF00D);
    applyStimulus("lhu_16", 1'b0, 32'h16, 3'b101, 32'h0, 0, got_rdata, got_err);
    checkOutput("lhu_16_const", got_rdata, 32'h0000F00D);

    applyStimulus("lh_11", 1'b0, 32'h11, 3'b001, 32'h0, 0, got_rdata, got_err);
    checkOutput("lh_11_err_const", 32'(got_err), 32'h1);
    applyStimulus("sw_12", 1'b1, 32'h12, 3'b010, 32'h12345678, 0, got_rdata, got_err);
    checkOutput("sw_12_err_const", 32'(got_err), 32'h1);
    applyStimulus("lw_10c", 1'b0, 32'h10, 3'b010, 32'h0, 0, got_rdata, got_err);
    checkOutput("lw_10c_const", got_rdata, 32'h80ADBEEF);

    applyStimulus("lw_hold", 1'b0, 32'h10, 3'b010, 32'h0, 5, got_rdata, got_err);
    repeat (3) begin
      @(negedge clock);
      checkOutput("ignored_pulse_idle", 32'(busy), 32'h0);
    end
    applyStimulus("lw_after_pulse", 1'b0, 32'h10, 3'b010, 32'h0, 0, got_rdata, got_err);
    checkOutput("lw_after_pulse_const", got_rdata, 32'h80ADBEEF);

    applyStimulus("sw_20", 1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 0, got_rdata, got_err);
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h20;
    req_funct3 = 3'b010;
    req_wdata  = 32'h11111111;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checkOutput("inflight_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("midrst_rdata", rsp_rdata, 32'h0);
    checkOutput("midrst_error", 32'(rsp_error), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    applyStimulus("lw_20", 1'b0, 32'h20, 3'b010, 32'h0, 0, got_rdata, got_err);
    checkOutput("lw_20_const", got_rdata, 32'hCAFEF00D);

    applyStimulus("ld_f3_011", 1'b0, 32'h10, 3'b011, 32'h0, 0, got_rdata, got_err);
    checkOutput("ld_f3_011_err_const", 32'(got_err), 32'h1);
    applyStimulus("lw_oor", 1'b0, 32'h00001000, 3'b010, 32'h0, 0, got_rdata, got_err);
    checkOutput("lw_oor_err_const", 32'(got_err), 32'h1);
    applyStimulus("sbu_10", 1'b1, 32'h10, 3'b100, 32'h00000055, 0, got_rdata, got_err);
    checkOutput("sbu_10_err_const", 32'(got_err), 32'h1);
    applyStimulus("lw_10d", 1'b0, 32'h10, 3'b010, 32'h0, 0, got_rdata, got_err);
    checkOutput("lw_10d_const", got_rdata, 32'h80ADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
